// File: rtl/uart_alu_ctrl.sv
// Frame controller between a UART FIFO pair and an external ALU.
// Receives A, B (LSB first) and an opcode byte, then returns the result or an error code.
module uart_alu_ctrl #(
  parameter int          DATA_W       = 8,
  parameter int          TIMEOUT_CLKS = 260400,
  parameter logic [7:0]  ERR_CODE     = 8'hEE
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_empty,
  input  logic [7:0]        i_r_data,
  output logic              o_rd_uart,
  input  logic              i_tx_full,
  output logic              o_wr_uart,
  output logic [7:0]        o_w_data,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [5:0]        o_alu_op,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_busy,
  output logic              o_err,
  output logic              o_timeout
);

  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(NB) + 1;
  localparam int TW = $clog2(TIMEOUT_CLKS) + 1;

  typedef enum logic [2:0] {IDLE, RECV_A, RECV_B, RECV_OP, EXEC, SEND, ERR} state_t;

  state_t            state;
  logic [CW-1:0]     bcnt;
  logic [TW-1:0]     tcnt;
  logic [DATA_W-1:0] a_sh;
  logic [DATA_W-1:0] b_sh;
  logic [DATA_W-1:0] result;

  logic receiving;
  logic pop;
  logic last;
  logic to_hit;

  assign receiving = (state == IDLE) || (state == RECV_A) ||
                     (state == RECV_B) || (state == RECV_OP);
  // Gated with reset so nothing is popped while reset is held low.
  assign pop       = i_reset && receiving && !i_rx_empty;
  assign last      = (bcnt == CW'(NB - 1));
  assign to_hit    = (tcnt == TW'(TIMEOUT_CLKS - 1));

  assign o_rd_uart = pop;
  assign o_wr_uart = i_reset && ((state == SEND) || (state == ERR)) && !i_tx_full;
  assign o_w_data  = (state == ERR) ? ERR_CODE : result[7:0];
  assign o_busy    = (state != IDLE);

  function automatic logic valid_op(input logic [7:0] op);
    case (op)
      8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27: valid_op = 1'b1;
      default:                                                valid_op = 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] v,
                                                 input logic [CW-1:0]     idx,
                                                 input logic [7:0]        b);
    logic [DATA_W-1:0] r;
    r = v;
    for (int unsigned k = 0; k < NB; k++) begin
      if (idx == CW'(k)) r[8*k +: 8] = b;
    end
    return r;
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= IDLE;
      bcnt      <= '0;
      tcnt      <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      result    <= '0;
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (pop) begin
            a_sh <= put_byte(a_sh, '0, i_r_data);
            if (NB == 1) begin
              state <= RECV_B;
              bcnt  <= '0;
            end else begin
              state <= RECV_A;
              bcnt  <= CW'(1);
            end
          end
        end
        RECV_A, RECV_B: begin
          if (pop) begin
            tcnt <= '0;
            if (state == RECV_A) a_sh <= put_byte(a_sh, bcnt, i_r_data);
            else                 b_sh <= put_byte(b_sh, bcnt, i_r_data);
            if (last) begin
              state <= (state == RECV_A) ? RECV_B : RECV_OP;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else if (to_hit) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
            bcnt      <= '0;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RECV_OP: begin
          if (pop) begin
            tcnt <= '0;
            bcnt <= '0;
            if (valid_op(i_r_data)) begin
              o_alu_a  <= a_sh;
              o_alu_b  <= b_sh;
              o_alu_op <= i_r_data[5:0];
              state    <= EXEC;
            end else begin
              o_err <= 1'b1;
              state <= ERR;
            end
          end else if (to_hit) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
            bcnt      <= '0;
            tcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        EXEC: begin
          result <= i_alu_result;
          bcnt   <= '0;
          tcnt   <= '0;
          state  <= SEND;
        end
        SEND: begin
          tcnt <= '0;
          if (!i_tx_full) begin
            result <= result >> 8;
            if (last) begin
              state <= IDLE;
              bcnt  <= '0;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        ERR: begin
          tcnt <= '0;
          if (!i_tx_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
